switch_egress_arbiter: RTL and testbench

//  Shares one switch egress port among NUM_PORTS ingress requesters (one switch_requester per ingress).
//  - Each requester presents a frame as an axis_d stream. A requester competes for this egress when tvalid=1 and tdest==PORT_ID.
//  - Rotating-priority (round-robin) grant, locked for a whole frame until the tlast handshake.
//  - Releases a stalled grant after an idle timeout. One instance per egress port.

---
 rtl/switch_pkg.sv | 34 +++
 rtl/switch_egress_arbiter_rr_priority_sel.sv | 33 +++
 rtl/switch_egress_arbiter.sv | 144 ++++++++++++++
 tb/tb_switch_egress_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared switch types: AXI-stream-with-dest source/sink structs, arbiter
// state encoding and the index-width helper used by every arbiter.
`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 4
`endif

package switch_pkg;

  localparam int AXIS_DATA_WIDTH = 32;

  // Forward (source-driven) half of an axis_d stream.
  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0]  tdata;
    logic                        tvalid;
    logic                        tlast;
    logic [`AXIS_DEST_WIDTH-1:0] tdest;
  } axis_d_source_t;

  // Backward (sink-driven) half of an axis_d stream.
  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int ARB_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/switch_egress_arbiter_rr_priority_sel.sv
// Rotating-priority encoder: picks the first asserted request at or after
// rr_ptr, wrapping modulo NUM_PORTS. Purely combinational and reusable.
module rr_priority_sel
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = ARB_IDX_W(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     rr_ptr,
  output logic                 any,
  output logic [IDX_W-1:0]     idx
);

  logic [IDX_W-1:0] cand;

  // Scan from rr_ptr upward; the first hit wins and later hits are ignored.
  always_comb begin
    // NOTE: every output gets a default before the loop, so no path leaves
    // it unassigned and no latch is inferred.
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/switch_egress_arbiter.sv
// One egress port shared by NUM_PORTS ingress requesters. Round-robin grant
// held for a whole frame, combinational pass-through while granted, and a
// stalled grant is dropped after an idle timeout. Frame/abort statistics.
module switch_egress_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_ID        = 0,
  parameter int IDLE_CTR_WIDTH = 6,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  axis_d_source_t [NUM_PORTS-1:0]       ingress_source,
  output axis_d_sink_t   [NUM_PORTS-1:0]       ingress_sink,
  output axis_d_source_t                       egress_source,
  input  axis_d_sink_t                         egress_sink,
  output logic                                 grant_valid,
  output logic [ARB_IDX_W(NUM_PORTS)-1:0]      grant_idx,
  output logic                                 abort_pulse,
  output logic [CNT_WIDTH-1:0]                 frames_fwd,
  output logic [CNT_WIDTH-1:0]                 frames_abort
);

  localparam int                 IDX_W     = ARB_IDX_W(NUM_PORTS);
  localparam int                 DEST_W    = `AXIS_DEST_WIDTH;
  localparam logic [DEST_W-1:0]  PORT_DEST = DEST_W'(PORT_ID);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NUM_PORTS - 1);

  arb_state_e                r_state;
  logic [IDX_W-1:0]          r_rr_ptr;
  logic [IDX_W-1:0]          r_grant_idx;
  logic [IDLE_CTR_WIDTH-1:0] r_idle_ctr;
  logic [CNT_WIDTH-1:0]      r_frames_fwd;
  logic [CNT_WIDTH-1:0]      r_frames_abort;

  logic [NUM_PORTS-1:0]      w_req;
  logic                      w_any;
  logic [IDX_W-1:0]          w_sel_idx;
  logic                      w_granted;
  logic                      w_granted_valid;
  logic                      w_frame_end;
  logic                      w_timeout;
  logic                      w_release;
  logic [IDX_W-1:0]          w_next_ptr;

  // A requester competes only while it is valid and addressed to this egress.
  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_req[i] = ingress_source[i].tvalid && (ingress_source[i].tdest == PORT_DEST);
    end
  end

  rr_priority_sel #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_sel (
    .req    (w_req),
    .rr_ptr (r_rr_ptr),
    .any    (w_any),
    .idx    (w_sel_idx)
  );

  // Pass the granted stream straight through; everyone else sees tready=0.
  always_comb begin
    egress_source = '0;
    ingress_sink  = '0;
    if (w_granted) begin
      egress_source                       = ingress_source[r_grant_idx];
      ingress_sink[r_grant_idx].tready    = egress_sink.tready;
    end
  end

  assign w_granted       = (r_state == GRANT);
  assign w_granted_valid = w_granted && ingress_source[r_grant_idx].tvalid;
  assign w_frame_end     = w_granted_valid && egress_sink.tready &&
                           ingress_source[r_grant_idx].tlast;
  // A tlast handshake in the same cycle as the timeout counts as forwarded.
  assign w_timeout       = w_granted && (r_idle_ctr == '1) && !w_frame_end;
  assign w_release       = w_frame_end || w_timeout;
  assign w_next_ptr      = (r_grant_idx == LAST_IDX) ? '0 : r_grant_idx + 1'b1;

  assign grant_valid  = w_granted;
  assign grant_idx    = r_grant_idx;
  assign abort_pulse  = w_timeout;
  assign frames_fwd   = r_frames_fwd;
  assign frames_abort = r_frames_abort;

  // Grant FSM: lock onto the selected requester until tlast or timeout;
  // the IDLE cycle after a release is the mandatory bubble.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_grant_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_idx <= w_sel_idx;
            r_state     <= GRANT;
          end
        end
        GRANT: begin
          if (w_release) begin
            r_state  <= IDLE;
            r_rr_ptr <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Count consecutive cycles the granted requester leaves tvalid low.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_idle_ctr <= '0;
    end else if (!w_granted || w_release || w_granted_valid) begin
      r_idle_ctr <= '0;
    end else begin
      r_idle_ctr <= r_idle_ctr + 1'b1;
    end
  end

  // Saturating frame statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frames_fwd   <= '0;
      r_frames_abort <= '0;
    end else begin
      if (w_frame_end && (r_frames_fwd != '1)) begin
        r_frames_fwd <= r_frames_fwd + 1'b1;
      end
      if (w_timeout && (r_frames_abort != '1)) begin
        r_frames_abort <= r_frames_abort + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_switch_egress_arbiter.sv
// Self-checking bench for switch_egress_arbiter: per-port source queues feed
// the DUT, expected egress beats sit in a scoreboard queue and are popped on
// every egress handshake; grant order, timeout and reset are checked directly.
module tb_switch_egress_arbiter;
  import switch_pkg::*;

  localparam int NP  = 4;
  localparam int PID = 0;
  localparam int ICW = 6;
  localparam int CW  = 16;
  localparam int IW  = ARB_IDX_W(NP);
  localparam int DW  = `AXIS_DEST_WIDTH;

  logic                      clk = 1'b0;
  logic                      reset;
  axis_d_source_t [NP-1:0]   ingress_source;
  axis_d_sink_t   [NP-1:0]   ingress_sink;
  axis_d_source_t            egress_source;
  axis_d_sink_t              egress_sink;
  logic                      grant_valid;
  logic [IW-1:0]             grant_idx;
  logic                      abort_pulse;
  logic [CW-1:0]             frames_fwd;
  logic [CW-1:0]             frames_abort;

  switch_egress_arbiter #(
    .NUM_PORTS      (NP),
    .PORT_ID        (PID),
    .IDLE_CTR_WIDTH (ICW),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ingress_source (ingress_source),
    .ingress_sink   (ingress_sink),
    .egress_source  (egress_source),
    .egress_sink    (egress_sink),
    .grant_valid    (grant_valid),
    .grant_idx      (grant_idx),
    .abort_pulse    (abort_pulse),
    .frames_fwd     (frames_fwd),
    .frames_abort   (frames_abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]   data;
    logic          last;
    logic [DW-1:0] dest;
  } beat_t;

  beat_t       src_q [NP][$];
  logic [32:0] exp_q [$];
  int          grant_log [$];
  bit          hold [NP];
  bit          stall [NP];
  bit          hs [NP];
  bit          saw_rdy [NP];
  int          valid_pct = 100;
  int          rdy_pct   = 100;
  int          n_cmp = 0;
  int          n_err = 0;
  int          frame_id = 0;
  bit          prev_stall = 1'b0;
  logic [32:0] prev_beat = '0;
  bit          prev_gv = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Queue one frame on a port; optionally record its beats as expected egress.
  task automatic load_frame(input int port, input int nb, input int dest, input bit push);
    beat_t b;
    frame_id++;
    for (int k = 0; k < nb; k++) begin
      b.data = {8'(port), 8'(frame_id), 16'(k)};
      b.last = (k == nb - 1);
      b.dest = DW'(dest);
      src_q[port].push_back(b);
      if (push) exp_q.push_back({b.last, b.data});
    end
  endtask

  // Present queue heads; once valid is shown it is held until accepted.
  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      ingress_source[i] = '0;
      if (src_q[i].size() > 0 && !stall[i]) begin
        if (!hold[i] && (int'($urandom_range(0, 99)) < valid_pct)) hold[i] = 1'b1;
        if (hold[i]) begin
          ingress_source[i].tdata  = src_q[i][0].data;
          ingress_source[i].tvalid = 1'b1;
          ingress_source[i].tlast  = src_q[i][0].last;
          ingress_source[i].tdest  = src_q[i][0].dest;
        end
      end
    end
    egress_sink.tready = (int'($urandom_range(0, 99)) < rdy_pct);
  endtask

  // Observe outputs mid-cycle: scoreboard, tready routing, stall stability.
  task automatic sample();
    logic exp_r;
    for (int i = 0; i < NP; i++) begin
      hs[i] = ingress_source[i].tvalid && ingress_sink[i].tready;
      exp_r = (grant_valid && grant_idx == IW'(i)) ? egress_sink.tready : 1'b0;
      check($sformatf("tready_p%0d", i), ingress_sink[i].tready, exp_r);
      if (ingress_sink[i].tready) saw_rdy[i] = 1'b1;
    end
    if (prev_stall) begin
      check("stall_valid_held", egress_source.tvalid, 1'b1);
      check("stall_beat_held", {egress_source.tlast, egress_source.tdata}, prev_beat);
    end
    prev_stall = egress_source.tvalid && !egress_sink.tready;
    prev_beat  = {egress_source.tlast, egress_source.tdata};
    if (egress_source.tvalid && egress_sink.tready) begin
      if (exp_q.size() == 0) check("spurious_beat", exp_q.size(), 1);
      else check("egress_beat", {egress_source.tlast, egress_source.tdata}, exp_q.pop_front());
    end
    if (grant_valid && !prev_gv) grant_log.push_back(int'(grant_idx));
    prev_gv = grant_valid;
  endtask

  task automatic commit();
    for (int i = 0; i < NP; i++) begin
      if (hs[i]) begin
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        hold[i] = 1'b0;
        hs[i]   = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    commit();
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic run_drain(input int budget, input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || grant_valid) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drain_timeout"}, (n >= budget), 1'b0);
  endtask

  // One reset cycle, then every output must be back at its reset value.
  task automatic reset_dut();
    reset = 1'b1;
    for (int i = 0; i < NP; i++) begin
      src_q[i].delete();
      hold[i] = 1'b0; stall[i] = 1'b0; hs[i] = 1'b0; saw_rdy[i] = 1'b0;
    end
    exp_q.delete();
    valid_pct = 100;
    rdy_pct   = 100;
    prev_stall = 1'b0;
    cycle();
    check("rst_grant_valid", grant_valid, 1'b0);
    check("rst_grant_idx", grant_idx, '0);
    check("rst_egress", egress_source, '0);
    check("rst_ingress_ready", ingress_sink, '0);
    check("rst_abort", abort_pulse, 1'b0);
    check("rst_frames_fwd", frames_fwd, '0);
    check("rst_frames_abort", frames_abort, '0);
    reset = 1'b0;
    grant_log.delete();
    prev_gv = 1'b0;
  endtask

  task automatic check_grants(input string tag, input int order[$]);
    check({tag, "_grant_count"}, grant_log.size(), order.size());
    for (int k = 0; k < order.size(); k++) begin
      check($sformatf("%s_grant%0d", tag, k),
            (k < grant_log.size()) ? grant_log[k] : -1, order[k]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ab;
    reset          = 1'b1;
    ingress_source = '0;
    egress_sink    = '0;
    reset_dut();

    // 1: single requester, 4-beat frame, one-cycle arbitration latency.
    load_frame(0, 4, PID, 1'b1);
    cycle();
    check("t1_no_grant_yet", grant_valid, 1'b0);
    check("t1_no_early_ready", ingress_sink[0].tready, 1'b0);
    check("t1_egress_idle", egress_source.tvalid, 1'b0);
    cycle();
    check("t1_grant_valid", grant_valid, 1'b1);
    check("t1_grant_idx", grant_idx, '0);
    run_drain(50, "t1");
    check("t1_frames_fwd", frames_fwd, 1);

    // 2: all four request; round-robin order with wrap to re-requesting port 2.
    reset_dut();
    load_frame(0, 3, PID, 1'b1);
    load_frame(1, 2, PID, 1'b1);
    load_frame(2, 4, PID, 1'b1);
    load_frame(3, 1, PID, 1'b1);
    load_frame(2, 2, PID, 1'b1);
    run_drain(200, "t2");
    check_grants("t2", '{0, 1, 2, 3, 2});
    check("t2_frames_fwd", frames_fwd, 5);

    // 3: port 1 addressed elsewhere never competes; port 2 is served.
    reset_dut();
    load_frame(1, 3, 5, 1'b0);
    load_frame(2, 3, PID, 1'b1);
    run_drain(50, "t3");
    check_grants("t3", '{2});
    check("t3_port1_never_ready", saw_rdy[1], 1'b0);

    // 4a: a 62-cycle gap inside a frame must not abort.
    reset_dut();
    load_frame(0, 2, PID, 1'b1);
    cycle();
    cycle();
    check("t4a_granted", grant_valid, 1'b1);
    stall[0] = 1'b1;
    ab = 1'b0;
    for (int k = 0; k < 62; k++) begin
      cycle();
      ab |= abort_pulse;
    end
    stall[0] = 1'b0;
    cycle();
    ab |= abort_pulse;
    check("t4a_no_abort_gap62", ab, 1'b0);
    run_drain(20, "t4a");
    check("t4a_frames_fwd", frames_fwd, 1);
    check("t4a_frames_abort", frames_abort, 0);

    // 4b: 63 idle cycles abort the grant; rr pointer then favours port 1.
    reset_dut();
    load_frame(0, 3, PID, 1'b0);
    exp_q.push_back({1'b0, src_q[0][0].data});
    cycle();
    cycle();
    check("t4b_granted", grant_valid, 1'b1);
    stall[0] = 1'b1;
    ab = 1'b0;
    for (int k = 0; k < 63; k++) begin
      cycle();
      ab |= abort_pulse;
    end
    check("t4b_no_early_abort", ab, 1'b0);
    cycle();
    check("t4b_abort_pulse", abort_pulse, 1'b1);
    src_q[0].delete();
    hold[0]  = 1'b0;
    stall[0] = 1'b0;
    load_frame(1, 2, PID, 1'b1);
    load_frame(0, 2, PID, 1'b1);
    cycle();
    check("t4b_abort_single", abort_pulse, 1'b0);
    check("t4b_released", grant_valid, 1'b0);
    check("t4b_frames_abort", frames_abort, 1);
    run_drain(50, "t4b");
    check_grants("t4b", '{0, 1, 0});
    check("t4b_frames_fwd", frames_fwd, 2);

    // 5: random source gaps and egress backpressure.
    reset_dut();
    valid_pct = 60;
    rdy_pct   = 50;
    load_frame(3, 5, PID, 1'b1);
    load_frame(3, 1, PID, 1'b1);
    load_frame(3, 7, PID, 1'b1);
    run_drain(600, "t5");
    check("t5_frames_fwd", frames_fwd, 3);
    check("t5_frames_abort", frames_abort, 0);

    // 6: reset on beat 2 of 5; rr pointer must be back at 0 afterwards.
    reset_dut();
    load_frame(1, 2, PID, 1'b1);
    run_drain(50, "t6a");
    check("t6_pre_frames_fwd", frames_fwd, 1);
    load_frame(2, 5, PID, 1'b0);
    for (int k = 0; k < 3; k++) exp_q.push_back({1'b0, src_q[2][k].data});
    for (int n = 0; n < 50 && src_q[2].size() > 3; n++) cycle();
    check("t6_mid_frame_grant", grant_valid, 1'b1);
    check("t6_mid_frame_port", grant_idx, 2);
    reset_dut();
    load_frame(0, 2, PID, 1'b1);
    load_frame(3, 2, PID, 1'b1);
    run_drain(50, "t6b");
    check_grants("t6", '{0, 3});
    check("t6_frames_fwd", frames_fwd, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
